udp_reg_ring_master: RTL and testbench
======================================

Name: udp_reg_ring_master

Overview:
- Head and tail of the UDP register ring.
- Accepts single-cycle register transactions from the CPU-side core interface and launches each onto the ring as a one-cycle reg_req.
- Waits for the same transaction to come back from the last ring stage (counter blocks, tables, etc.) and returns the read data and status to the core.
- Generates a timeout response if nothing returns, and an unclaimed response if the transaction returns un-acked.

Parameters:
- UDP_REG_ADDR_WIDTH, 23, ring address width.
- DATA_WIDTH, 32, register data width (matches CPCI_NF2_DATA_WIDTH).
- UDP_REG_SRC_WIDTH, 2, ring source field width; must be >= 2.
- SRC_ID, 0, master identifier placed in src[UDP_REG_SRC_WIDTH-1:1].
- TIMEOUT_CYCLES, 127, cycles spent in WAIT before timeout; >= 1.
- UNCLAIMED_DATA, 32'hDEAD_BEEF, read data returned when the ring returns ack=0.
- TIMEOUT_DATA, 32'hDEAD_0000, read data returned on timeout.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- core_reg_req  in  1  single-cycle request pulse
- core_reg_rd_wr_L  in  1  1=read, 0=write
- core_reg_addr  in  UDP_REG_ADDR_WIDTH  target address
- core_reg_wr_data  in  DATA_WIDTH  write data
- core_reg_ack  out  1  single-cycle completion pulse
- core_reg_rd_data  out  DATA_WIDTH  read data, valid with ack
- core_reg_err  out  1  timeout or unclaimed, valid with ack
- core_reg_busy  out  1  transaction outstanding
- reg_req_out, reg_ack_out, reg_rd_wr_L_out  out  1 each  ring launch
- reg_addr_out  out  UDP_REG_ADDR_WIDTH  ring launch
- reg_data_out  out  DATA_WIDTH  ring launch
- reg_src_out  out  UDP_REG_SRC_WIDTH  ring launch
- reg_req_in, reg_ack_in, reg_rd_wr_L_in  in  1 each  ring return
- reg_addr_in  in  UDP_REG_ADDR_WIDTH  ring return
- reg_data_in  in  DATA_WIDTH  ring return
- reg_src_in  in  UDP_REG_SRC_WIDTH  ring return

Behaviour:
- All outputs registered.
- Reset values:
  - all ring outputs 0;
  - core_reg_ack, core_reg_err, core_reg_busy 0;
  - core_reg_rd_data 0;
  - seq bit 0; state IDLE; timeout counter 0.
- State IDLE:
  - core_reg_req=1 latches rd_wr_L, addr, wr_data and toggles seq.
  - Next cycle: reg_req_out=1 with latched fields, reg_ack_out=0, reg_src_out={SRC_ID, seq}, and reg_data_out = wr_data for a write, 0 for a read.
  - Goes to WAIT; core_reg_busy=1 from that cycle.
- reg_req_out is high for exactly one cycle per transaction. Other ring outputs hold their last values when req is 0.
- State WAIT, timeout counter increments each cycle:
  - Return match: reg_req_in=1 and reg_src_in equals the launched src.
    - reg_ack_in=1 -> rd_data=reg_data_in, err=0.
    - reg_ack_in=0 -> rd_data=UNCLAIMED_DATA, err=1.
    - Go to DONE.
  - Counter reaches TIMEOUT_CYCLES with no match -> rd_data=TIMEOUT_DATA, err=1, go to DONE.
  - A match on the same cycle as the timeout wins over the timeout.
- State DONE: core_reg_ack=1 for one cycle; busy clears in the same cycle; go to IDLE.
- Write completion: ack with rd_data = returned reg_data_in, which is the echoed write data.
- core_reg_req while busy or in DONE: dropped, with no other effect. The core must sample core_reg_busy before issuing.
- A new request is accepted in the cycle after the ack pulse at the earliest.
- reg_req_in with a non-matching src, or arriving in IDLE/DONE (late return after timeout): discarded. The seq toggle guarantees a late return never matches the next transaction.
- Latency: request at cycle 0 -> reg_req_out at cycle 1 -> return at cycle 1+L (L = ring latency) -> core_reg_ack at cycle 2+L.
- Reset mid-transaction: abort, no ack issued, all outputs return to reset values next cycle. A later return is discarded by the IDLE rule.
- Timeout counter width: log2(TIMEOUT_CYCLES+1). Cleared on every entry to WAIT.

Decomposition:
- Shared package (ring defines): UDP_REG_ADDR_WIDTH, CPCI_NF2_DATA_WIDTH, UNCLAIMED/TIMEOUT data constants, state encodings, log2 function.
- Sub-module udp_reg_timeout_cntr: clear, enable, expire flag. Everything else stays inline.

Test Plan:
- Read hit: ring model of 3 counter stages (L=6) acks addr 0x000004 with 0x0000_0042 -> core_reg_ack at cycle 8, rd_data=0x42, err=0, reg_req_out high exactly 1 cycle.
- Write: write 0x1234_5678 to a claimed address -> reg_data_out=0x12345678, reg_rd_wr_L_out=0, ack with err=0, rd_data=0x12345678.
- Unclaimed: address with no owner (return ack=0) -> rd_data=0xDEADBEEF, err=1.
- Timeout: ring model swallows the request, TIMEOUT_CYCLES=15 -> ack at cycle 1+15+1, rd_data=0xDEAD0000, err=1. Inject the late return at cycle 30 during a new transaction -> ignored, new transaction completes with its own data.
- Busy drop and foreign src: second core_reg_req during WAIT -> no second reg_req_out. A return with src={SRC_ID,~seq} -> ignored, real return accepted.
- Reset in WAIT: assert reset for 1 cycle -> no ack, busy=0, all ring outputs 0. The subsequent return is discarded; the next request starts with seq=1.

Source files
------------

// File: rtl/udp_reg_ring_master_pkg.sv
// Shared definitions for the UDP register ring: default widths, error data words,
// master state encoding and a ceiling-log2 helper for counter sizing.
package udp_reg_ring_master_pkg;

    localparam int UDP_REG_ADDR_WIDTH  = 23;
    localparam int CPCI_NF2_DATA_WIDTH = 32;

    localparam logic [31:0] UNCLAIMED_DATA_DEFAULT = 32'hDEAD_BEEF;
    localparam logic [31:0] TIMEOUT_DATA_DEFAULT   = 32'hDEAD_0000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } ring_state_t;

    // Smallest width able to index `value` distinct codes; never less than 1.
    function automatic int log2_ceil(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return (result < 1) ? 1 : result;
    endfunction

endpackage

// File: rtl/udp_reg_timeout_cntr.sv
// Wait-state cycle counter: cleared when a transaction is launched, counts while
// enabled and flags expiry once LIMIT cycles have been counted.
module udp_reg_timeout_cntr #(
    parameter int LIMIT = 127,
    parameter int WIDTH = 7
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [WIDTH-1:0] count_reg;

    assign expired = (count_reg == WIDTH'(LIMIT));

    // Holds at LIMIT so the flag stays asserted until the next clear.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count_reg <= '0;
        end else if (enable && !expired) begin
            count_reg <= count_reg + 1'b1;
        end
    end

endmodule

// File: rtl/udp_reg_ring_master.sv
// Head and tail of the UDP register ring: launches one core transaction at a time
// onto the ring and turns its return (or a timeout) into a single-cycle core ack.
module udp_reg_ring_master #(
    parameter int UDP_REG_ADDR_WIDTH = udp_reg_ring_master_pkg::UDP_REG_ADDR_WIDTH,
    parameter int DATA_WIDTH         = udp_reg_ring_master_pkg::CPCI_NF2_DATA_WIDTH,
    parameter int UDP_REG_SRC_WIDTH  = 2,
    parameter int SRC_ID             = 0,
    parameter int TIMEOUT_CYCLES     = 127,
    parameter logic [DATA_WIDTH-1:0] UNCLAIMED_DATA =
        DATA_WIDTH'(udp_reg_ring_master_pkg::UNCLAIMED_DATA_DEFAULT),
    parameter logic [DATA_WIDTH-1:0] TIMEOUT_DATA =
        DATA_WIDTH'(udp_reg_ring_master_pkg::TIMEOUT_DATA_DEFAULT)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          core_reg_req,
    input  logic                          core_reg_rd_wr_L,
    input  logic [UDP_REG_ADDR_WIDTH-1:0] core_reg_addr,
    input  logic [DATA_WIDTH-1:0]         core_reg_wr_data,
    output logic                          core_reg_ack,
    output logic [DATA_WIDTH-1:0]         core_reg_rd_data,
    output logic                          core_reg_err,
    output logic                          core_reg_busy,
    output logic                          reg_req_out,
    output logic                          reg_ack_out,
    output logic                          reg_rd_wr_L_out,
    output logic [UDP_REG_ADDR_WIDTH-1:0] reg_addr_out,
    output logic [DATA_WIDTH-1:0]         reg_data_out,
    output logic [UDP_REG_SRC_WIDTH-1:0]  reg_src_out,
    input  logic                          reg_req_in,
    input  logic                          reg_ack_in,
    input  logic                          reg_rd_wr_L_in,
    input  logic [UDP_REG_ADDR_WIDTH-1:0] reg_addr_in,
    input  logic [DATA_WIDTH-1:0]         reg_data_in,
    input  logic [UDP_REG_SRC_WIDTH-1:0]  reg_src_in
);

    import udp_reg_ring_master_pkg::*;

    localparam int CNT_WIDTH = log2_ceil(TIMEOUT_CYCLES + 1);
    localparam logic [UDP_REG_SRC_WIDTH-2:0] SRC_ID_FIELD = (UDP_REG_SRC_WIDTH-1)'(SRC_ID);

    ring_state_t state_reg, state_next;

    logic                          seq_reg;
    logic                          core_reg_ack_reg;
    logic [DATA_WIDTH-1:0]         core_reg_rd_data_reg;
    logic                          core_reg_err_reg;
    logic                          core_reg_busy_reg;
    logic                          reg_req_out_reg;
    logic                          reg_ack_out_reg;
    logic                          reg_rd_wr_L_out_reg;
    logic [UDP_REG_ADDR_WIDTH-1:0] reg_addr_out_reg;
    logic [DATA_WIDTH-1:0]         reg_data_out_reg;
    logic [UDP_REG_SRC_WIDTH-1:0]  reg_src_out_reg;

    logic launch;
    logic finish;
    logic ret_match;
    logic timer_expired;

    // Returned address and direction are echoes of what was launched; only src identifies it.
    logic unused_ring_fields;
    assign unused_ring_fields = ^{reg_rd_wr_L_in, reg_addr_in};

    // The held launch src doubles as the tag of the outstanding transaction.
    assign ret_match = reg_req_in && (reg_src_in == reg_src_out_reg);

    udp_reg_timeout_cntr #(
        .LIMIT (TIMEOUT_CYCLES),
        .WIDTH (CNT_WIDTH)
    ) u_timeout_cntr (
        .clk     (clk),
        .reset   (reset),
        .clear   (launch),
        .enable  (state_reg == ST_WAIT),
        .expired (timer_expired)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        launch     = 1'b0;
        finish     = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (core_reg_req) begin
                    launch     = 1'b1;
                    state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (ret_match || timer_expired) begin
                    finish     = 1'b1;
                    state_next = ST_DONE;
                end
            end
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            seq_reg              <= 1'b0;
            core_reg_ack_reg     <= 1'b0;
            core_reg_rd_data_reg <= '0;
            core_reg_err_reg     <= 1'b0;
            core_reg_busy_reg    <= 1'b0;
            reg_req_out_reg      <= 1'b0;
            reg_ack_out_reg      <= 1'b0;
            reg_rd_wr_L_out_reg  <= 1'b0;
            reg_addr_out_reg     <= '0;
            reg_data_out_reg     <= '0;
            reg_src_out_reg      <= '0;
        end else begin
            reg_req_out_reg  <= launch;
            core_reg_ack_reg <= finish;
            if (launch) begin
                seq_reg             <= ~seq_reg;
                reg_ack_out_reg     <= 1'b0;
                reg_rd_wr_L_out_reg <= core_reg_rd_wr_L;
                reg_addr_out_reg    <= core_reg_addr;
                reg_data_out_reg    <= core_reg_rd_wr_L ? '0 : core_reg_wr_data;
                reg_src_out_reg     <= {SRC_ID_FIELD, ~seq_reg};
                core_reg_busy_reg   <= 1'b1;
            end
            // A return arriving on the expiry cycle still counts as a real response.
            if (finish) begin
                core_reg_busy_reg <= 1'b0;
                if (ret_match) begin
                    core_reg_rd_data_reg <= reg_ack_in ? reg_data_in : UNCLAIMED_DATA;
                    core_reg_err_reg     <= ~reg_ack_in;
                end else begin
                    core_reg_rd_data_reg <= TIMEOUT_DATA;
                    core_reg_err_reg     <= 1'b1;
                end
            end
        end
    end

    assign core_reg_ack     = core_reg_ack_reg;
    assign core_reg_rd_data = core_reg_rd_data_reg;
    assign core_reg_err     = core_reg_err_reg;
    assign core_reg_busy    = core_reg_busy_reg;
    assign reg_req_out      = reg_req_out_reg;
    assign reg_ack_out      = reg_ack_out_reg;
    assign reg_rd_wr_L_out  = reg_rd_wr_L_out_reg;
    assign reg_addr_out     = reg_addr_out_reg;
    assign reg_data_out     = reg_data_out_reg;
    assign reg_src_out      = reg_src_out_reg;

endmodule

// File: tb/tb_udp_reg_ring_master.sv
// Scoreboard bench: a ring model answers launches after a chosen latency, a reference
// model predicts each core response, and monitors compare launches and acks.
module tb_udp_reg_ring_master;

    localparam int AW     = 23;
    localparam int DW     = 32;
    localparam int SW     = 2;
    localparam int SRC_ID = 1;
    localparam int TO     = 15;
    localparam logic [31:0] UNCL_DATA = 32'hDEAD_BEEF;
    localparam logic [31:0] TO_DATA   = 32'hDEAD_0000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset;
    logic          core_reg_req;
    logic          core_reg_rd_wr_L;
    logic [AW-1:0] core_reg_addr;
    logic [DW-1:0] core_reg_wr_data;
    logic          core_reg_ack;
    logic [DW-1:0] core_reg_rd_data;
    logic          core_reg_err;
    logic          core_reg_busy;
    logic          reg_req_out, reg_ack_out, reg_rd_wr_L_out;
    logic [AW-1:0] reg_addr_out;
    logic [DW-1:0] reg_data_out;
    logic [SW-1:0] reg_src_out;
    logic          reg_req_in, reg_ack_in, reg_rd_wr_L_in;
    logic [AW-1:0] reg_addr_in;
    logic [DW-1:0] reg_data_in;
    logic [SW-1:0] reg_src_in;

    udp_reg_ring_master #(
        .UDP_REG_SRC_WIDTH (SW),
        .SRC_ID            (SRC_ID),
        .TIMEOUT_CYCLES    (TO)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .core_reg_req     (core_reg_req),
        .core_reg_rd_wr_L (core_reg_rd_wr_L),
        .core_reg_addr    (core_reg_addr),
        .core_reg_wr_data (core_reg_wr_data),
        .core_reg_ack     (core_reg_ack),
        .core_reg_rd_data (core_reg_rd_data),
        .core_reg_err     (core_reg_err),
        .core_reg_busy    (core_reg_busy),
        .reg_req_out      (reg_req_out),
        .reg_ack_out      (reg_ack_out),
        .reg_rd_wr_L_out  (reg_rd_wr_L_out),
        .reg_addr_out     (reg_addr_out),
        .reg_data_out     (reg_data_out),
        .reg_src_out      (reg_src_out),
        .reg_req_in       (reg_req_in),
        .reg_ack_in       (reg_ack_in),
        .reg_rd_wr_L_in   (reg_rd_wr_L_in),
        .reg_addr_in      (reg_addr_in),
        .reg_data_in      (reg_data_in),
        .reg_src_in       (reg_src_in)
    );

    typedef struct {
        logic [31:0] rd_data;
        logic        err;
        int          cycle;
    } resp_t;

    typedef struct {
        logic          rd;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [SW-1:0] src;
    } launch_t;

    typedef struct {
        int            due;
        logic          ack;
        logic          rd;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [SW-1:0] src;
    } ret_t;

    resp_t   exp_q[$];
    launch_t launch_q[$];
    ret_t    ring_q[$];

    logic [31:0] ring_regs  [logic [AW-1:0]];
    logic [31:0] model_regs [logic [AW-1:0]];

    int          cycle_cnt = 0;
    int          checks    = 0;
    int          errors    = 0;
    int          txn_cnt   = 0;
    int          ring_lat  = 6;
    bit          ring_swallow = 1'b0;
    int          inject_cycle = -1;
    logic [SW-1:0] inject_src  = '0;
    logic [31:0]   inject_data = '0;
    bit          seq_model = 1'b0;

    always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cycle_cnt);
        end
    endtask

    // Ring model: owned addresses are those present in ring_regs; everything is echoed back.
    initial begin
        ret_t r;
        reg_req_in = 1'b0; reg_ack_in = 1'b0; reg_rd_wr_L_in = 1'b0;
        reg_addr_in = '0; reg_data_in = '0; reg_src_in = '0;
        forever begin
            @(negedge clk);
            reg_req_in = 1'b0;
            if (reg_req_out && !ring_swallow) begin
                r.due  = cycle_cnt + ring_lat;
                r.rd   = reg_rd_wr_L_out;
                r.addr = reg_addr_out;
                r.src  = reg_src_out;
                if (ring_regs.exists(reg_addr_out)) begin
                    r.ack = 1'b1;
                    if (!reg_rd_wr_L_out) ring_regs[reg_addr_out] = reg_data_out;
                    r.data = ring_regs[reg_addr_out];
                end else begin
                    r.ack  = 1'b0;
                    r.data = reg_data_out;
                end
                ring_q.push_back(r);
            end
            if (inject_cycle == cycle_cnt) begin
                reg_req_in = 1'b1; reg_ack_in = 1'b1; reg_rd_wr_L_in = 1'b1;
                reg_addr_in = '0; reg_data_in = inject_data; reg_src_in = inject_src;
            end else begin
                for (int i = 0; i < ring_q.size(); i++) begin
                    if (ring_q[i].due == cycle_cnt) begin
                        reg_req_in = 1'b1; reg_ack_in = ring_q[i].ack;
                        reg_rd_wr_L_in = ring_q[i].rd; reg_addr_in = ring_q[i].addr;
                        reg_data_in = ring_q[i].data; reg_src_in = ring_q[i].src;
                        ring_q.delete(i);
                        break;
                    end
                end
            end
        end
    end

    // Launch monitor: every reg_req_out cycle must correspond to one expected launch.
    initial begin
        launch_t l;
        forever begin
            @(negedge clk);
            if (reg_req_out) begin
                if (launch_q.size() == 0) begin
                    check("extra_launch", 64'(reg_req_out), 64'd0);
                end else begin
                    l = launch_q.pop_front();
                    check("launch_fields",
                          64'({reg_ack_out, reg_rd_wr_L_out, reg_addr_out, reg_data_out, reg_src_out}),
                          64'({1'b0, l.rd, l.addr, l.data, l.src}));
                    check("busy_at_launch", 64'(core_reg_busy), 64'd1);
                end
            end
        end
    end

    // Response monitor.
    initial begin
        resp_t e;
        forever begin
            @(negedge clk);
            if (core_reg_ack) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_ack", 64'(core_reg_ack), 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    txn_cnt++;
                    check("rd_data", 64'(core_reg_rd_data), 64'(e.rd_data));
                    check("err", 64'(core_reg_err), 64'(e.err));
                    check("ack_cycle", 64'(cycle_cnt), 64'(e.cycle));
                    check("busy_at_ack", 64'(core_reg_busy), 64'd0);
                    $display("txn %0d: ack cycle=%0d rd_data=0x%08h err=%0d", txn_cnt, cycle_cnt,
                             core_reg_rd_data, core_reg_err);
                end
            end
        end
    end

    // Issue one request at the current negedge and record what the spec predicts.
    task automatic issue(input logic rd, input logic [AW-1:0] addr, input logic [31:0] data,
                         input int lat, input bit swallow);
        resp_t   r;
        launch_t l;
        bit      owned;
        ring_lat         = lat;
        ring_swallow     = swallow;
        core_reg_rd_wr_L = rd;
        core_reg_addr    = addr;
        core_reg_wr_data = data;
        core_reg_req     = 1'b1;
        seq_model        = ~seq_model;
        l.rd   = rd;
        l.addr = addr;
        l.data = rd ? 32'd0 : data;
        l.src  = SW'((SRC_ID << 1) | int'(seq_model));
        launch_q.push_back(l);
        owned = model_regs.exists(addr);
        if (swallow || lat > TO) begin
            r.rd_data = TO_DATA; r.err = 1'b1; r.cycle = cycle_cnt + TO + 2;
        end else if (!owned) begin
            r.rd_data = UNCL_DATA; r.err = 1'b1; r.cycle = cycle_cnt + lat + 2;
        end else begin
            r.rd_data = rd ? model_regs[addr] : data; r.err = 1'b0; r.cycle = cycle_cnt + lat + 2;
        end
        if (!swallow && owned && !rd) model_regs[addr] = data;
        exp_q.push_back(r);
        @(negedge clk);
        core_reg_req = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("response_arrived", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
        @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ring_out"},
              64'({reg_req_out, reg_ack_out, reg_rd_wr_L_out, reg_addr_out, reg_data_out, reg_src_out}),
              64'd0);
        check({tag, "_core_out"},
              64'({core_reg_ack, core_reg_err, core_reg_busy, core_reg_rd_data}), 64'd0);
    endtask

    logic [AW-1:0] addr_tab [7];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; core_reg_req = 1'b0; core_reg_rd_wr_L = 1'b1;
        core_reg_addr = '0; core_reg_wr_data = '0;
        addr_tab = '{23'h000004, 23'h000008, 23'h000010, 23'h000020,
                     23'h000044, 23'h000104, 23'h7FFFFC};
        ring_regs[23'h04] = 32'h0000_0042; model_regs[23'h04] = 32'h0000_0042;
        ring_regs[23'h08] = 32'h1111_0008; model_regs[23'h08] = 32'h1111_0008;
        ring_regs[23'h10] = 32'h2222_0010; model_regs[23'h10] = 32'h2222_0010;
        ring_regs[23'h20] = 32'h3333_0020; model_regs[23'h20] = 32'h3333_0020;
        ring_regs[23'h44] = 32'h4444_0044; model_regs[23'h44] = 32'h4444_0044;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        reset = 1'b0;
        @(negedge clk);

        // Read hit, write, read-back, unclaimed.
        issue(1'b1, 23'h04, 32'd0, 6, 1'b0);          wait_idle();
        issue(1'b0, 23'h10, 32'h1234_5678, 6, 1'b0);  wait_idle();
        issue(1'b1, 23'h10, 32'd0, 3, 1'b0);          wait_idle();
        issue(1'b1, 23'h104, 32'd0, 6, 1'b0);         wait_idle();

        // Timeout with a late return landing inside the next transaction's wait.
        issue(1'b1, 23'h08, 32'd0, 30, 1'b0);         wait_idle();
        issue(1'b1, 23'h20, 32'd0, 14, 1'b0);         wait_idle();

        // Return on the expiry cycle wins; one cycle later it is a timeout.
        issue(1'b1, 23'h44, 32'd0, TO, 1'b0);         wait_idle();
        issue(1'b1, 23'h44, 32'd0, TO + 1, 1'b0);     wait_idle();
        issue(1'b1, 23'h04, 32'd0, 5, 1'b1);          wait_idle();

        // Request dropped while busy, and a return carrying the other seq value.
        issue(1'b1, 23'h08, 32'd0, 10, 1'b0);
        inject_cycle = cycle_cnt + 3;
        inject_src   = SW'((SRC_ID << 1) | int'(~seq_model));
        inject_data  = 32'hBAD0_BAD0;
        @(negedge clk);
        core_reg_addr = 23'h10; core_reg_req = 1'b1;
        @(negedge clk);
        core_reg_req = 1'b0;
        wait_idle();

        // Reset while waiting: no ack, outputs cleared, late return ignored, seq restarts.
        issue(1'b1, 23'h20, 32'd0, 10, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_reset_outputs("midreset");
        reset = 1'b0;
        exp_q.delete();
        seq_model = 1'b0;
        repeat (12) @(negedge clk);
        issue(1'b1, 23'h20, 32'd0, 6, 1'b0);          wait_idle();

        // Randomized traffic.
        for (int t = 0; t < 24; t++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            issue(1'($urandom_range(0, 1)), addr_tab[$urandom_range(0, 6)], $urandom,
                  int'($urandom_range(1, TO + 1)), ($urandom_range(0, 9) == 0));
            wait_idle();
        end

        repeat (20) @(negedge clk);
        check("pending_responses", 64'(exp_q.size()), 64'd0);
        check("pending_launches", 64'(launch_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
